cw_fetch: RTL

- Control-word fetch stage sitting directly downstream of the NISC program counter.
- Presents the PC value to a synchronous program ROM and captures the returned control words in a 2-entry buffer.
- Hands control words to the datapath over a valid/ready handshake.
- Drives the PC `hold` input so that no fetched word is ever lost or duplicated.

---
 rtl/cw_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cw_fetch.sv
// ---------------------------------------------------------------------------
// cw_fetch: control-word fetch stage between the NISC program counter and
// the datapath.
//
// The current PC value is presented straight to a synchronous program ROM.
// Words come back one cycle later and are captured into a 2-entry FIFO.
// The datapath drains the FIFO over a valid/ready handshake. The PC is
// throttled through `hold` so that no word is ever lost or duplicated.
//
// Ports:
//   clk       in   system clock, rising edge
//   nReset    in   asynchronous active-low reset
//   pc_addr   in   current PC value [Psize]
//   hold      out  1 = PC must not advance this cycle
//   rom_addr  out  ROM read address [Psize], equal to pc_addr
//   rom_data  in   ROM read data [Wsize], valid 1 cycle after rom_addr
//   flush     in   discard buffered and in-flight words (branch redirect)
//   cw        out  control word at buffer head [Wsize]
//   cw_valid  out  cw holds a valid word
//   cw_ready  in   datapath accepts cw this cycle
// ---------------------------------------------------------------------------
module cw_fetch #(
    parameter int unsigned Psize = 4,
    parameter int unsigned Wsize = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [Psize-1:0] pc_addr,
    output logic             hold,
    output logic [Psize-1:0] rom_addr,
    input  logic [Wsize-1:0] rom_data,
    input  logic             flush,
    output logic [Wsize-1:0] cw,
    output logic             cw_valid,
    input  logic             cw_ready
);

    // Buffer storage and bookkeeping
    logic [Wsize-1:0] mem_q [2];
    logic [Wsize-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             pending_q, pending_d;

    logic       pop;
    logic       issue;
    logic       capture;
    logic [2:0] occupancy;

    // The ROM is addressed by the PC directly; the PC itself is the fetch
    // address register, so there is no extra stage here.
    assign rom_addr = pc_addr;

    // Head of buffer comes from registered storage only.
    assign cw       = mem_q[rd_ptr_q];
    assign cw_valid = (count_q != 2'd0);

    always_comb begin
        pop       = cw_valid & cw_ready;
        // Words buffered plus the one in flight: a slot must be guaranteed
        // for every word requested, unless a pop frees one this same cycle.
        occupancy = {1'b0, count_q} + {2'b00, pending_q};
        // Gating with nReset keeps the PC held for the whole reset period.
        issue     = nReset & ~flush & ((occupancy < 3'd2) | pop);
        hold      = ~issue;
        // The word returning in a flush cycle belongs to the old stream.
        capture   = pending_q & ~flush;
    end

    always_comb begin
        mem_d[0]  = mem_q[0];
        mem_d[1]  = mem_q[1];
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pending_d = issue;

        if (flush) begin
            // A pop in this cycle is still a completed handshake; its effect
            // is subsumed by emptying the buffer.
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (capture) begin
                mem_d[wr_ptr_q] = rom_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({capture, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // The issue rule keeps buffered + in-flight words within capacity.
    count_le_two: assert property (@(posedge clk) disable iff (!nReset)
        count_q <= 2'd2);

    occupancy_le_two: assert property (@(posedge clk) disable iff (!nReset)
        occupancy <= 3'd2);

endmodule
